// File: rtl/skein_pkg.sv
// Shared Skein/Threefish definitions: block-size modes, word counts and the
// forward/inverse word-permutation tables used by threefish_permute_unit.
package skein_pkg;

  typedef enum logic [1:0] {
    MODE_256  = 2'd0,
    MODE_512  = 2'd1,
    MODE_1024 = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } perm_state_t;

  localparam logic [4:0] NW_256  = 5'd4;
  localparam logic [4:0] NW_512  = 5'd8;
  localparam logic [4:0] NW_1024 = 5'd16;

  // Output word i takes input word TABLE[i].
  localparam logic [3:0] PERM_FWD_4 [4] = '{4'd0, 4'd3, 4'd2, 4'd1};
  localparam logic [3:0] PERM_FWD_8 [8] = '{4'd2, 4'd1, 4'd4, 4'd7, 4'd6, 4'd5, 4'd0, 4'd3};
  localparam logic [3:0] PERM_FWD_16 [16] = '{
    4'd0, 4'd9, 4'd2, 4'd13, 4'd6, 4'd11, 4'd4, 4'd15,
    4'd10, 4'd7, 4'd12, 4'd3, 4'd14, 4'd5, 4'd8, 4'd1
  };
  localparam logic [3:0] PERM_INV_4 [4] = '{4'd0, 4'd3, 4'd2, 4'd1};
  localparam logic [3:0] PERM_INV_8 [8] = '{4'd6, 4'd1, 4'd0, 4'd7, 4'd2, 4'd5, 4'd4, 4'd3};
  localparam logic [3:0] PERM_INV_16 [16] = '{
    4'd0, 4'd15, 4'd2, 4'd11, 4'd6, 4'd13, 4'd4, 4'd9,
    4'd14, 4'd7, 4'd8, 4'd5, 4'd10, 4'd3, 4'd12, 4'd1
  };

  function automatic logic [4:0] words_per_mode(input mode_t mode);
    case (mode)
      MODE_256: words_per_mode = NW_256;
      MODE_512: words_per_mode = NW_512;
      default:  words_per_mode = NW_1024;
    endcase
  endfunction

  function automatic logic [3:0] last_index(input mode_t mode);
    logic [4:0] nw;
    nw = words_per_mode(mode) - 5'd1;
    last_index = nw[3:0];
  endfunction

endpackage

// File: rtl/permute_index_rom.sv
// Combinational (mode, inv, index) -> source word index lookup.
// The inverse tables are only built when PERMUTE_INV_EN is defined.
module permute_index_rom
  import skein_pkg::*;
(
  input  mode_t      mode,
`ifdef PERMUTE_INV_EN
  input  logic       inv,
`endif
  input  logic [3:0] idx,
  output logic [3:0] src
);

  // Table select by block size; reserved mode shares the 1024-bit table.
  always_comb begin
    src = 4'd0;
`ifdef PERMUTE_INV_EN
    if (inv) begin
      case (mode)
        MODE_256: src = PERM_INV_4[idx[1:0]];
        MODE_512: src = PERM_INV_8[idx[2:0]];
        default:  src = PERM_INV_16[idx];
      endcase
    end else begin
      case (mode)
        MODE_256: src = PERM_FWD_4[idx[1:0]];
        MODE_512: src = PERM_FWD_8[idx[2:0]];
        default:  src = PERM_FWD_16[idx];
      endcase
    end
`else
    case (mode)
      MODE_256: src = PERM_FWD_4[idx[1:0]];
      MODE_512: src = PERM_FWD_8[idx[2:0]];
      default:  src = PERM_FWD_16[idx];
    endcase
`endif
  end

endmodule

// File: rtl/threefish_permute_unit.sv
// Word-serial Threefish permutation: buffers a 4/8/16-word block, then emits it
// in permuted order. PERMUTE_INV_EN adds the inv_i port and inverse tables.
module threefish_permute_unit
  import skein_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_i,
`ifdef PERMUTE_INV_EN
  input  logic              inv_i,
`endif
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic [3:0]        out_idx_o,
  output logic              out_last_o
);

  perm_state_t       state;
  mode_t             mode_q;
  logic [3:0]        wr_cnt;
  logic [3:0]        rd_cnt;
  logic [3:0]        src_idx;
  logic [3:0]        last_idx;
  logic [WORD_W-1:0] word_buf [16];
`ifdef PERMUTE_INV_EN
  logic              inv_q;
`endif

  assign last_idx = last_index(mode_q);

  permute_index_rom u_rom (
    .mode (mode_q),
`ifdef PERMUTE_INV_EN
    .inv  (inv_q),
`endif
    .idx  (rd_cnt),
    .src  (src_idx)
  );

  // Block FSM: counters, latched mode/inv and FILL/DRAIN sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      wr_cnt <= 4'd0;
      rd_cnt <= 4'd0;
      mode_q <= MODE_256;
`ifdef PERMUTE_INV_EN
      inv_q  <= 1'b0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (in_valid_i) begin
            if (wr_cnt == 4'd0) begin
              mode_q <= mode_t'(mode_i);
`ifdef PERMUTE_INV_EN
              inv_q  <= inv_i;
`endif
            end
            // The first word can never be the last, so mode_q is already valid here.
            if ((wr_cnt != 4'd0) && (wr_cnt == last_idx)) begin
              state  <= DRAIN;
              wr_cnt <= 4'd0;
              rd_cnt <= 4'd0;
            end else begin
              wr_cnt <= wr_cnt + 4'd1;
            end
          end
        end
        DRAIN: begin
          if (out_ready_i) begin
            if (rd_cnt == last_idx) begin
              state  <= FILL;
              rd_cnt <= 4'd0;
            end else begin
              rd_cnt <= rd_cnt + 4'd1;
            end
          end
        end
        default: begin
          state  <= FILL;
          wr_cnt <= 4'd0;
          rd_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Block buffer; contents are only visible during DRAIN so it needs no reset.
  always_ff @(posedge clk) begin
    if ((state == FILL) && in_valid_i) begin
      word_buf[wr_cnt] <= in_data_i;
    end
  end

  assign in_ready_o  = (state == FILL);
  assign out_valid_o = (state == DRAIN);
  assign out_data_o  = (state == DRAIN) ? word_buf[src_idx] : {WORD_W{1'b0}};
  assign out_idx_o   = (state == DRAIN) ? rd_cnt : 4'd0;
  assign out_last_o  = (state == DRAIN) && (rd_cnt == last_idx);

endmodule
